fwd_select_unit: RTL and testbench

//  Generates the registered 3-bit forwarding selects for the EX-stage operand

---
 rtl/fwd_select_unit_if.sv | 31 +++
 rtl/fwd_select_unit.sv | 129 ++++++++++++
 tb/tb_fwd_select_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_select_unit_if.sv
// Decode-to-forwarding-unit bus for fwd_select_unit.
// master: decode side (drives the instruction fields and flush).
// slave : the forwarding unit (drives stall_out and the EX mux selects).
interface fwd_select_unit_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_we;
  logic                  id_is_load;
  logic                  flush;
  logic                  stall_out;
  logic [2:0]            fwd_sel_a;
  logic [2:0]            fwd_sel_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_we, id_is_load, flush,
    input  stall_out, fwd_sel_a, fwd_sel_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_we, id_is_load, flush,
    output stall_out, fwd_sel_a, fwd_sel_b
  );
endinterface

// File: rtl/fwd_select_unit.sv
// fwd_select_unit: registered EX operand forwarding selects and load-use stall.
// Select codes: 000 = regfile, 001 = EX/MEM result, 010 = MEM/WB result.
// Optional build macro FWD_ZERO_REG_EN: register 0 is hard-zero and is never
// forwarded from nor stalled on.
// Only the EX and MEM slots are stored: the regfile is write-through, so a
// producer that has reached WB never affects a select or a stall, and the
// load flag is only consulted while the producer sits in EX.
module fwd_select_unit #(
  parameter int REG_ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  fwd_select_unit_if.slave bus
);

  localparam logic [2:0] SEL_RF  = 3'b000;
  localparam logic [2:0] SEL_MEM = 3'b001;
  localparam logic [2:0] SEL_WB  = 3'b010;

  // EX slot
  logic                  ex_valid_r;
  logic [REG_ADDR_W-1:0] ex_rd_r;
  logic                  ex_we_r;
  logic                  ex_load_r;
  // MEM slot
  logic                  mem_valid_r;
  logic [REG_ADDR_W-1:0] mem_rd_r;
  logic                  mem_we_r;
  // Registered selects
  logic [2:0]            sel_a_r;
  logic [2:0]            sel_b_r;

  logic                  hit_ex_a_s;
  logic                  hit_ex_b_s;
  logic                  hit_mem_a_s;
  logic                  hit_mem_b_s;
  logic [2:0]            sel_a_s;
  logic [2:0]            sel_b_s;
  logic                  stall_s;
  logic                  advance_s;

  // A slot produces the value a source needs.
  function automatic logic hit_f(
    input logic                  valid,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  used
  );
    logic zero_ok;
`ifdef FWD_ZERO_REG_EN
    zero_ok = (rd != {REG_ADDR_W{1'b0}});
`else
    zero_ok = 1'b1;
`endif
    return valid & we & used & (rd == rs) & zero_ok;
  endfunction

  // Decode-time hit detection, select priority and load-use stall.
  always_comb begin
    hit_ex_a_s  = hit_f(ex_valid_r, ex_we_r, ex_rd_r, bus.id_rs1, bus.id_rs1_used);
    hit_ex_b_s  = hit_f(ex_valid_r, ex_we_r, ex_rd_r, bus.id_rs2, bus.id_rs2_used);
    hit_mem_a_s = hit_f(mem_valid_r, mem_we_r, mem_rd_r, bus.id_rs1, bus.id_rs1_used);
    hit_mem_b_s = hit_f(mem_valid_r, mem_we_r, mem_rd_r, bus.id_rs2, bus.id_rs2_used);

    // Youngest producer (EX) wins over MEM.
    if (hit_ex_a_s) begin
      sel_a_s = SEL_MEM;
    end else if (hit_mem_a_s) begin
      sel_a_s = SEL_WB;
    end else begin
      sel_a_s = SEL_RF;
    end

    if (hit_ex_b_s) begin
      sel_b_s = SEL_MEM;
    end else if (hit_mem_b_s) begin
      sel_b_s = SEL_WB;
    end else begin
      sel_b_s = SEL_RF;
    end

    // A load in EX cannot supply its data yet; flush kills the consumer so it wins.
    stall_s   = ~rst & bus.id_valid & ~bus.flush & ex_load_r & (hit_ex_a_s | hit_ex_b_s);
    advance_s = bus.id_valid & ~bus.flush & ~stall_s;
  end

  // Slot pipeline advance and select registration on ID->EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r  <= 1'b0;
      ex_rd_r     <= {REG_ADDR_W{1'b0}};
      ex_we_r     <= 1'b0;
      ex_load_r   <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_rd_r    <= {REG_ADDR_W{1'b0}};
      mem_we_r    <= 1'b0;
      sel_a_r     <= SEL_RF;
      sel_b_r     <= SEL_RF;
    end else begin
      mem_valid_r <= ex_valid_r;
      mem_rd_r    <= ex_rd_r;
      mem_we_r    <= ex_we_r;
      if (bus.flush || stall_s) begin
        ex_valid_r <= 1'b0;
        ex_rd_r    <= {REG_ADDR_W{1'b0}};
        ex_we_r    <= 1'b0;
        ex_load_r  <= 1'b0;
      end else begin
        ex_valid_r <= bus.id_valid;
        ex_rd_r    <= bus.id_rd;
        ex_we_r    <= bus.id_we;
        ex_load_r  <= bus.id_is_load;
      end
      if (advance_s) begin
        sel_a_r <= sel_a_s;
        sel_b_r <= sel_b_s;
      end else begin
        sel_a_r <= SEL_RF;
        sel_b_r <= SEL_RF;
      end
    end
  end

  assign bus.stall_out = stall_s;
  assign bus.fwd_sel_a = sel_a_r;
  assign bus.fwd_sel_b = sel_b_r;

endmodule

// File: tb/tb_fwd_select_unit.sv
// Self-checking bench for fwd_select_unit: directed scenarios plus a random
// run checked against a queue-based model of the in-flight instructions.
module tb_fwd_select_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fwd_select_unit_if #(.REG_ADDR_W(4)) bus ();

  fwd_select_unit #(.REG_ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the last two instructions that entered EX, youngest first.
  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       we;
    logic       ld;
  } slot_t;

  slot_t      pipe_q[$];
  slot_t      nxt_entry;
  logic       nxt_rst;
  logic       exp_stall;
  logic [2:0] nxt_sel_a, nxt_sel_b;
  logic [2:0] exp_sel_a, exp_sel_b;

  // Age (1 = one stage ahead, 2 = two stages ahead) of the youngest producer of rs, 0 if none.
  function automatic int producer_age(input logic [3:0] rs, input logic used);
    if (!used) return 0;
`ifdef FWD_ZERO_REG_EN
    if (rs == 4'd0) return 0;
`endif
    foreach (pipe_q[i]) begin
      if (pipe_q[i].v && pipe_q[i].we && pipe_q[i].rd == rs) return i + 1;
    end
    return 0;
  endfunction

  task automatic clear_model();
    slot_t bubble;
    bubble = '0;
    pipe_q = {};
    pipe_q.push_back(bubble);
    pipe_q.push_back(bubble);
    exp_sel_a = 3'b000;
    exp_sel_b = 3'b000;
  endtask

  // Present one decode-stage instruction and work out what the model expects.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic ua, input logic ub, input logic [3:0] d,
                       input logic we, input logic ld, input logic fl);
    int age_a, age_b;
    bus.id_valid = v; bus.id_rs1 = a; bus.id_rs2 = b;
    bus.id_rs1_used = ua; bus.id_rs2_used = ub;
    bus.id_rd = d; bus.id_we = we; bus.id_is_load = ld; bus.flush = fl;
    #1;
    age_a = producer_age(a, ua);
    age_b = producer_age(b, ub);
    exp_stall = !rst && v && !fl && pipe_q[0].ld && (age_a == 1 || age_b == 1);
    if (rst || !v || fl || exp_stall) begin
      nxt_sel_a = 3'b000;
      nxt_sel_b = 3'b000;
    end else begin
      nxt_sel_a = 3'(age_a);
      nxt_sel_b = 3'(age_b);
    end
    nxt_entry = '0;
    if (v && !fl && !exp_stall) begin
      nxt_entry.v = 1'b1; nxt_entry.rd = d; nxt_entry.we = we; nxt_entry.ld = ld;
    end
    nxt_rst = rst;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (nxt_rst) begin
      clear_model();
    end else begin
      pipe_q.push_front(nxt_entry);
      void'(pipe_q.pop_back());
      exp_sel_a = nxt_sel_a;
      exp_sel_b = nxt_sel_b;
    end
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
      n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_out); end
      tick();
      n_checks++; if (bus.fwd_sel_a !== 3'b000) begin n_fail++; $display("FAIL reset_sel_a: got %b want 000", bus.fwd_sel_a); end
      n_checks++; if (bus.fwd_sel_b !== 3'b000) begin n_fail++; $display("FAIL reset_sel_b: got %b want 000", bus.fwd_sel_b); end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    nop(); nop();
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0); tick();   // ADD r3
    drive(1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);           // SUB rs1=r3
    n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", bus.stall_out); end
    tick();
    n_checks++; if (bus.fwd_sel_a !== 3'b001) begin n_fail++; $display("FAIL b2b_sel_a: got %b want 001", bus.fwd_sel_a); end
    n_checks++; if (bus.fwd_sel_b !== 3'b000) begin n_fail++; $display("FAIL b2b_sel_b: got %b want 000", bus.fwd_sel_b); end
  endtask

  task automatic test_mem_forward();
    nop(); nop();
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0); tick();   // ADD r3
    nop();
    drive(1'b1, 4'd8, 4'd3, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0); tick();   // SUB rs2=r3
    n_checks++; if (bus.fwd_sel_b !== 3'b010) begin n_fail++; $display("FAIL mem_sel_b: got %b want 010", bus.fwd_sel_b); end
    n_checks++; if (bus.fwd_sel_a !== 3'b000) begin n_fail++; $display("FAIL mem_sel_a: got %b want 000", bus.fwd_sel_a); end
  endtask

  task automatic test_youngest_wins();
    nop(); nop();
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0); tick();   // ADD r5
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0); tick();   // ADD r5
    drive(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0); tick();   // AND r5,r5
    n_checks++; if (bus.fwd_sel_a !== 3'b001) begin n_fail++; $display("FAIL young_sel_a: got %b want 001", bus.fwd_sel_a); end
    n_checks++; if (bus.fwd_sel_b !== 3'b001) begin n_fail++; $display("FAIL young_sel_b: got %b want 001", bus.fwd_sel_b); end
  endtask

  task automatic test_load_use();
    nop(); nop();
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0); tick();   // LD r4
    drive(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);           // ADD rs1=r4
    n_checks++; if (bus.stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", bus.stall_out); end
    tick();
    n_checks++; if (bus.fwd_sel_a !== 3'b000) begin n_fail++; $display("FAIL lu_bubble_a: got %b want 000", bus.fwd_sel_a); end
    n_checks++; if (bus.fwd_sel_b !== 3'b000) begin n_fail++; $display("FAIL lu_bubble_b: got %b want 000", bus.fwd_sel_b); end
    drive(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);           // held consumer
    n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b want 0", bus.stall_out); end
    tick();
    n_checks++; if (bus.fwd_sel_a !== 3'b010) begin n_fail++; $display("FAIL lu_sel_a: got %b want 010", bus.fwd_sel_a); end
  endtask

  task automatic test_flush_stall();
    nop(); nop();
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0); tick();   // LD r4
    drive(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1);           // use r4, flushed
    n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %b want 0", bus.stall_out); end
    tick();
    n_checks++; if (bus.fwd_sel_a !== 3'b000) begin n_fail++; $display("FAIL fl_sel_a: got %b want 000", bus.fwd_sel_a); end
    n_checks++; if (bus.fwd_sel_b !== 3'b000) begin n_fail++; $display("FAIL fl_sel_b: got %b want 000", bus.fwd_sel_b); end
  endtask

  task automatic test_reset_mid_stall();
    nop(); nop();
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0); tick();   // LD r4
    drive(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.stall_out !== 1'b1) begin n_fail++; $display("FAIL rms_pre: got %b want 1", bus.stall_out); end
    rst = 1'b1;
    drive(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL rms_drop: got %b want 0", bus.stall_out); end
    tick();
    rst = 1'b0;
    drive(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL rms_residual: got %b want 0", bus.stall_out); end
    tick();
    n_checks++; if (bus.fwd_sel_a !== 3'b000) begin n_fail++; $display("FAIL rms_sel_a: got %b want 000", bus.fwd_sel_a); end
  endtask

  task automatic test_zero_reg();
    nop(); nop();
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0); tick();   // ADD r0
    drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0); tick();   // use r0
`ifdef FWD_ZERO_REG_EN
    n_checks++; if (bus.fwd_sel_a !== 3'b000) begin n_fail++; $display("FAIL zero_sel_a: got %b want 000", bus.fwd_sel_a); end
    n_checks++; if (bus.fwd_sel_b !== 3'b000) begin n_fail++; $display("FAIL zero_sel_b: got %b want 000", bus.fwd_sel_b); end
`else
    n_checks++; if (bus.fwd_sel_a !== 3'b001) begin n_fail++; $display("FAIL zero_sel_a: got %b want 001", bus.fwd_sel_a); end
    n_checks++; if (bus.fwd_sel_b !== 3'b001) begin n_fail++; $display("FAIL zero_sel_b: got %b want 001", bus.fwd_sel_b); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      n_checks++;
      if (bus.stall_out !== exp_stall) begin
        n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", i, bus.stall_out, exp_stall);
      end
      tick();
      n_checks++;
      if (bus.fwd_sel_a !== exp_sel_a || bus.fwd_sel_b !== exp_sel_b) begin
        n_fail++;
        $display("FAIL rand_sel[%0d]: got a=%b b=%b want a=%b b=%b", i,
                 bus.fwd_sel_a, bus.fwd_sel_b, exp_sel_a, exp_sel_b);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs1 = 4'd0; bus.id_rs2 = 4'd0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.id_rd = 4'd0; bus.id_we = 1'b0; bus.id_is_load = 1'b0; bus.flush = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_mem_forward();
    test_youngest_wins();
    test_load_use();
    test_flush_stall();
    test_reset_mid_stall();
    test_zero_reg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
